// File: rtl/i2c_reg_sequencer_if.sv
// Byte-engine and register-bank signals seen by the I2C register sequencer.
// The slave modport is the sequencer; the master modport is the engine plus bank side.
interface i2c_reg_sequencer_if #(
   parameter int AW = 3
);
   logic          start_det;
   logic          stop_det;
   logic          rx_valid;
   logic [7:0]    rx_byte;
   logic          ack_valid;
   logic          ack;
   logic          tx_req;
   logic          tx_valid;
   logic [7:0]    tx_byte;
   logic          tx_done;
   logic          tx_nack;
   logic [AW-1:0] reg_addr;
   logic          reg_we;
   logic [7:0]    reg_wdata;
   logic [7:0]    reg_rdata;

   modport slave (
      input  start_det, stop_det, rx_valid, rx_byte, tx_req, tx_done, tx_nack, reg_rdata,
      output ack_valid, ack, tx_valid, tx_byte, reg_addr, reg_we, reg_wdata
   );

   modport master (
      output start_det, stop_det, rx_valid, rx_byte, tx_req, tx_done, tx_nack, reg_rdata,
      input  ack_valid, ack, tx_valid, tx_byte, reg_addr, reg_we, reg_wdata
   );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// I2C slave transaction sequencer: address decode, register pointer, writes and
// auto-incrementing reads; owns every ACK/NACK decision for the byte engine.
module i2c_reg_sequencer #(
   parameter logic [6:0] DEV_ADDR = 7'h55,
   parameter int         NUM_REGS = 8,
   parameter int         AW       = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   output logic busy,
   i2c_reg_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR   = 3'd1,
      S_PTR    = 3'd2,
      S_WRITE  = 3'd3,
      S_READ   = 3'd4,
      S_IGNORE = 3'd5
   } state_t;

   localparam logic [AW-1:0] LAST_PTR   = AW'(NUM_REGS - 1);
   localparam logic [8:0]    NUM_REGS_W = 9'(NUM_REGS);

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          inc_q, inc_d;
   logic          ack_valid_q, ack_valid_d;
   logic          ack_q, ack_d;
   logic          tx_valid_q, tx_valid_d;
   logic [7:0]    tx_byte_q, tx_byte_d;
   logic          reg_we_q, reg_we_d;
   logic [7:0]    reg_wdata_q, reg_wdata_d;
   logic          busy_q, busy_d;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      if (p == LAST_PTR) begin
         next_ptr = {AW{1'b0}};
      end else begin
         next_ptr = p + AW'(1);
      end
   endfunction

   // Next-state and registered-output logic; the pointer advances one cycle
   // after its write/read strobe so the strobe cycle still shows the old address.
   always_comb begin
      state_d     = state_q;
      ptr_d       = inc_q ? next_ptr(ptr_q) : ptr_q;
      inc_d       = 1'b0;
      ack_valid_d = 1'b0;
      ack_d       = ack_q;
      tx_valid_d  = 1'b0;
      tx_byte_d   = tx_byte_q;
      reg_we_d    = 1'b0;
      reg_wdata_d = reg_wdata_q;

      if (!ena) begin
         state_d = S_IDLE;
      end else if (bus.start_det) begin
         state_d = S_ADDR;
      end else if (bus.stop_det) begin
         state_d = S_IDLE;
      end else begin
         if (bus.rx_valid) begin
            case (state_q)
               S_ADDR: begin
                  ack_valid_d = 1'b1;
                  if (bus.rx_byte[7:1] == DEV_ADDR) begin
                     ack_d   = 1'b1;
                     state_d = bus.rx_byte[0] ? S_READ : S_PTR;
                  end else begin
                     ack_d   = 1'b0;
                     state_d = S_IGNORE;
                  end
               end
               S_PTR: begin
                  ack_valid_d = 1'b1;
                  if ({1'b0, bus.rx_byte} < NUM_REGS_W) begin
                     ptr_d   = bus.rx_byte[AW-1:0];
                     ack_d   = 1'b1;
                     state_d = S_WRITE;
                  end else begin
                     ack_d   = 1'b0;
                     state_d = S_IGNORE;
                  end
               end
               S_WRITE: begin
                  ack_valid_d = 1'b1;
                  ack_d       = 1'b1;
                  reg_we_d    = 1'b1;
                  reg_wdata_d = bus.rx_byte;
                  inc_d       = 1'b1;
               end
               S_IGNORE: begin
                  ack_valid_d = 1'b1;
                  ack_d       = 1'b0;
               end
               default: begin
                  ack_valid_d = 1'b0;
               end
            endcase
         end else begin
            ack_valid_d = 1'b0;
         end

         if (bus.tx_req) begin
            tx_valid_d = 1'b1;
            if (state_q == S_READ) begin
               tx_byte_d = bus.reg_rdata;
               inc_d     = 1'b1;
            end else begin
               tx_byte_d = 8'hFF;
            end
         end else begin
            tx_valid_d = 1'b0;
         end

         if (bus.tx_done && bus.tx_nack && (state_q == S_READ)) begin
            state_d = S_IGNORE;
         end else begin
            inc_d = inc_d;
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   // State, pointer and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= {AW{1'b0}};
         inc_q       <= 1'b0;
         ack_valid_q <= 1'b0;
         ack_q       <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_byte_q   <= 8'h00;
         reg_we_q    <= 1'b0;
         reg_wdata_q <= 8'h00;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         inc_q       <= inc_d;
         ack_valid_q <= ack_valid_d;
         ack_q       <= ack_d;
         tx_valid_q  <= tx_valid_d;
         tx_byte_q   <= tx_byte_d;
         reg_we_q    <= reg_we_d;
         reg_wdata_q <= reg_wdata_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.ack_valid = ack_valid_q;
   assign bus.ack       = ack_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.tx_byte   = tx_byte_q;
   assign bus.reg_addr  = ptr_q;
   assign bus.reg_we    = reg_we_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Scoreboard bench for i2c_reg_sequencer: expected ACKs, register writes and
// transmit bytes are queued as stimulus is driven and matched as the DUT emits them.
module tb_i2c_reg_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b1;
   logic busy;

   int checks = 0;
   int errors = 0;

   logic        exp_ack[$];
   logic [10:0] exp_wr[$];
   logic [7:0]  exp_tx[$];
   logic [7:0]  bank[8];

   i2c_reg_sequencer_if #(.AW(3)) bus ();

   i2c_reg_sequencer #(.DEV_ADDR(7'h55), .NUM_REGS(8), .AW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .busy  (busy),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Register bank model: combinational read, write on the strobe.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
      end else if (bus.reg_we) begin
         bank[bus.reg_addr] <= bus.reg_wdata;
      end
   end
   assign bus.reg_rdata = bank[bus.reg_addr];

   // Scoreboard: every strobe seen must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.ack_valid) begin
         checks++;
         if (exp_ack.size() == 0) begin
            errors++;
            $display("FAIL ack_unexpected: got ack=%0b, expected no ack_valid", bus.ack);
         end else begin
            logic e;
            e = exp_ack.pop_front();
            if (bus.ack !== e) begin
               errors++;
               $display("FAIL ack_value: got %0b, expected %0b", bus.ack, e);
            end
         end
      end
      if (bus.reg_we) begin
         checks++;
         if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected: got addr=%0d data=%h, expected no reg_we", bus.reg_addr, bus.reg_wdata);
         end else begin
            logic [10:0] w;
            w = exp_wr.pop_front();
            if ({bus.reg_addr, bus.reg_wdata} !== w) begin
               errors++;
               $display("FAIL wr_value: got addr=%0d data=%h, expected addr=%0d data=%h",
                        bus.reg_addr, bus.reg_wdata, w[10:8], w[7:0]);
            end
         end
      end
      if (bus.tx_valid) begin
         checks++;
         if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got tx_byte=%h, expected no tx_valid", bus.tx_byte);
         end else begin
            logic [7:0] t;
            t = exp_tx.pop_front();
            if (bus.tx_byte !== t) begin
               errors++;
               $display("FAIL tx_value: got %h, expected %h", bus.tx_byte, t);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      bus.start_det = 1'b1; tick(); bus.start_det = 1'b0;
   endtask

   task automatic do_stop();
      bus.stop_det = 1'b1; tick(); bus.stop_det = 1'b0;
   endtask

   task automatic do_rx(input logic [7:0] b);
      bus.rx_byte = b; bus.rx_valid = 1'b1; tick(); bus.rx_valid = 1'b0;
   endtask

   task automatic do_tx(input logic nack);
      bus.tx_req = 1'b1; tick(); bus.tx_req = 1'b0;
      bus.tx_done = 1'b1; bus.tx_nack = nack; tick(); bus.tx_done = 1'b0; bus.tx_nack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      checks++;
      if ({bus.ack_valid, bus.ack, bus.tx_valid, bus.reg_we, busy} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_flags: got %b, expected 00000",
                  {bus.ack_valid, bus.ack, bus.tx_valid, bus.reg_we, busy});
      end
      checks++;
      if ({bus.tx_byte, bus.reg_wdata} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_bytes: got %h, expected 0000", {bus.tx_byte, bus.reg_wdata});
      end
      checks++;
      if (bus.reg_addr !== 3'd0) begin
         errors++;
         $display("FAIL reset_addr: got %0d, expected 0", bus.reg_addr);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write_burst();
      do_start();
      exp_ack.push_back(1'b1); do_rx(8'hAA);
      exp_ack.push_back(1'b1); do_rx(8'h02);
      exp_ack.push_back(1'b1); exp_wr.push_back({3'd2, 8'h11}); do_rx(8'h11);
      exp_ack.push_back(1'b1); exp_wr.push_back({3'd3, 8'h22}); do_rx(8'h22);
      do_stop();
      repeat (2) tick();
      checks++;
      if (bus.reg_addr !== 3'd4) begin
         errors++;
         $display("FAIL burst_addr: got %0d, expected 4", bus.reg_addr);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL burst_busy: got %0b, expected 0", busy);
      end
      checks++;
      if (exp_ack.size() + exp_wr.size() != 0) begin
         errors++;
         $display("FAIL burst_pending: got %0d outstanding, expected 0", exp_ack.size() + exp_wr.size());
      end
   endtask

   task automatic test_wrong_addr();
      do_start();
      exp_ack.push_back(1'b0); do_rx(8'hA8);
      exp_ack.push_back(1'b0); do_rx(8'h01);
      exp_ack.push_back(1'b0); do_rx(8'h55);
      repeat (2) tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL wrong_busy: got %0b, expected 1", busy);
      end
      do_stop();
      tick();
      checks++;
      if (exp_ack.size() != 0 || bus.reg_addr !== 3'd4) begin
         errors++;
         $display("FAIL wrong_end: got pending=%0d addr=%0d, expected 0 and 4", exp_ack.size(), bus.reg_addr);
      end
   endtask

   task automatic test_ptr_range();
      do_start();
      exp_ack.push_back(1'b1); do_rx(8'hAA);
      exp_ack.push_back(1'b0); do_rx(8'h08);
      exp_ack.push_back(1'b0); do_rx(8'h33);
      do_stop();
      repeat (2) tick();
      checks++;
      if (exp_ack.size() != 0 || bus.reg_addr !== 3'd4) begin
         errors++;
         $display("FAIL range_end: got pending=%0d addr=%0d, expected 0 and 4", exp_ack.size(), bus.reg_addr);
      end
   endtask

   task automatic test_read_wrap();
      // Load reg7=0x77 and (after the wrap) reg0=0xA0 through the DUT itself.
      do_start();
      exp_ack.push_back(1'b1); do_rx(8'hAA);
      exp_ack.push_back(1'b1); do_rx(8'h07);
      exp_ack.push_back(1'b1); exp_wr.push_back({3'd7, 8'h77}); do_rx(8'h77);
      exp_ack.push_back(1'b1); exp_wr.push_back({3'd0, 8'hA0}); do_rx(8'hA0);
      do_start();
      exp_ack.push_back(1'b1); do_rx(8'hAA);
      exp_ack.push_back(1'b1); do_rx(8'h07);
      do_start();
      exp_ack.push_back(1'b1); do_rx(8'hAB);
      exp_tx.push_back(8'h77); do_tx(1'b0);
      exp_tx.push_back(8'hA0); do_tx(1'b1);
      tick();
      checks++;
      if (bus.reg_addr !== 3'd1) begin
         errors++;
         $display("FAIL read_addr: got %0d, expected 1", bus.reg_addr);
      end
      exp_ack.push_back(1'b0); do_rx(8'h5A);
      do_stop();
      repeat (2) tick();
      checks++;
      if (exp_ack.size() + exp_wr.size() + exp_tx.size() != 0) begin
         errors++;
         $display("FAIL read_pending: got %0d outstanding, expected 0",
                  exp_ack.size() + exp_wr.size() + exp_tx.size());
      end
   endtask

   task automatic test_tx_idle();
      exp_tx.push_back(8'hFF);
      bus.tx_req = 1'b1; tick(); bus.tx_req = 1'b0;
      repeat (2) tick();
      checks++;
      if (exp_tx.size() != 0 || bus.reg_addr !== 3'd1) begin
         errors++;
         $display("FAIL idle_tx: got pending=%0d addr=%0d, expected 0 and 1", exp_tx.size(), bus.reg_addr);
      end
   endtask

   task automatic test_collisions();
      do_start();
      exp_ack.push_back(1'b1); do_rx(8'hAA);
      exp_ack.push_back(1'b1); do_rx(8'h05);
      bus.stop_det = 1'b1; bus.rx_byte = 8'h44; bus.rx_valid = 1'b1;
      tick();
      bus.stop_det = 1'b0; bus.rx_valid = 1'b0;
      repeat (2) tick();
      checks++;
      if (busy !== 1'b0 || bus.reg_addr !== 3'd5) begin
         errors++;
         $display("FAIL stop_collide: got busy=%0b addr=%0d, expected 0 and 5", busy, bus.reg_addr);
      end
      // Enable drop: back to IDLE, pointer kept.
      do_start();
      exp_ack.push_back(1'b1); do_rx(8'hAA);
      ena = 1'b0; tick(); ena = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || bus.reg_addr !== 3'd5) begin
         errors++;
         $display("FAIL ena_low: got busy=%0b addr=%0d, expected 0 and 5", busy, bus.reg_addr);
      end
      do_start();
      exp_ack.push_back(1'b1); do_rx(8'hAA);
      exp_ack.push_back(1'b1); do_rx(8'h06);
      rst_n = 1'b0; bus.rx_byte = 8'h66; bus.rx_valid = 1'b1;
      tick();
      rst_n = 1'b1; bus.rx_valid = 1'b0;
      repeat (2) tick();
      checks++;
      if (busy !== 1'b0 || bus.reg_addr !== 3'd0 || bus.reg_wdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_collide: got busy=%0b addr=%0d wdata=%h, expected 0, 0, 00",
                  busy, bus.reg_addr, bus.reg_wdata);
      end
      checks++;
      if (exp_ack.size() + exp_wr.size() != 0) begin
         errors++;
         $display("FAIL collide_pending: got %0d outstanding, expected 0", exp_ack.size() + exp_wr.size());
      end
   endtask

   initial begin
      bus.start_det = 1'b0;
      bus.stop_det  = 1'b0;
      bus.rx_valid  = 1'b0;
      bus.rx_byte   = 8'h00;
      bus.tx_req    = 1'b0;
      bus.tx_done   = 1'b0;
      bus.tx_nack   = 1'b0;
      test_reset();
      test_write_burst();
      test_wrong_addr();
      test_ptr_range();
      test_read_wrap();
      test_tx_idle();
      test_collisions();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded 200000 time units, expected completion");
      $fatal(1);
   end

endmodule
